// File: rtl/ex_pipe_ctrl_pkg.sv
// Shared types and constants for the execute-stage pipeline sequencing controller.
package ex_pipe_ctrl_pkg;

   localparam int EX_REG_W = 3;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } ex_state_e;

endpackage

// File: rtl/ex_pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush debug event counts.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/ex_pipe_ctrl.sv
// Execute-stage sequencing: stall/flush/redirect decisions, halt drain, debug counters.
//   state | meaning
//   RUN   | normal issue; resolves mem_busy, halt, redirect, load-use in that order
//   DRAIN | halt seen in EX; front end frozen while older instructions retire
//   HALT  | core frozen; only rst leaves
module ex_pipe_ctrl
   import ex_pipe_ctrl_pkg::*;
#(
   parameter int REG_W        = EX_REG_W,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic             id_rs_vld,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_rt_vld,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_regwrt,
   input  logic             ex_memread,
   input  logic             ex_brchcnd,
   input  logic             ex_alujmp,
   input  logic             ex_dmp,
   input  logic             mem_busy,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_stall,
   output logic             pc_redirect,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

   ex_state_e     state_q, state_d;
   logic [DW-1:0] drain_q, drain_d;

   logic redirect;
   logic load_use;

   assign redirect = ex_brchcnd | ex_alujmp;
   assign load_use = ex_memread & ex_regwrt &
                     ((id_rs_vld & (id_rs == ex_rd)) | (id_rt_vld & (id_rt == ex_rd)));

   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_stall = 1'b0;
      pc_redirect = 1'b0;
      halted      = 1'b0;
      // Outputs are Mealy on the inputs, so mask them while reset is held.
      if (!rst) begin
         case (state_q)
            ST_RUN: begin
               if (mem_busy) begin
                  pc_stall    = 1'b1;
                  ifid_stall  = 1'b1;
                  exmem_stall = 1'b1;
                  idex_flush  = 1'b1;
               end else if (ex_dmp) begin
                  pc_stall   = 1'b1;
                  ifid_stall = 1'b1;
                  idex_flush = 1'b1;
                  state_d    = ST_DRAIN;
                  drain_d    = DRAIN_INIT;
               end else if (redirect) begin
                  pc_redirect = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
               end else if (load_use) begin
                  pc_stall   = 1'b1;
                  ifid_stall = 1'b1;
                  idex_flush = 1'b1;
               end
            end
            ST_DRAIN: begin
               pc_stall   = 1'b1;
               ifid_stall = 1'b1;
               idex_flush = 1'b1;
               if (mem_busy) begin
                  exmem_stall = 1'b1;
               end else if (drain_q == '0) begin
                  state_d = ST_HALT;
               end else begin
                  drain_d = drain_q - 1'b1;
               end
            end
            ST_HALT: begin
               halted      = 1'b1;
               pc_stall    = 1'b1;
               ifid_stall  = 1'b1;
               exmem_stall = 1'b1;
               idex_flush  = 1'b1;
            end
            default: begin
               state_d = ST_RUN;
               drain_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   logic stall_inc;
   assign stall_inc = pc_stall & (state_q != ST_HALT);

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (pc_redirect),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// Directed bench for ex_pipe_ctrl; a second CNT_W=4 instance covers counter saturation.
module tb_ex_pipe_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] id_rs, id_rt, ex_rd;
   logic       id_rs_vld, id_rt_vld, ex_regwrt, ex_memread;
   logic       ex_brchcnd, ex_alujmp, ex_dmp, mem_busy;

   logic        pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall, pc_redirect, halted;
   logic [15:0] stall_cnt, flush_cnt;

   logic        s_pc_stall, s_ifid_stall, s_ifid_flush, s_idex_flush, s_exmem_stall, s_pc_redirect, s_halted;
   logic [3:0]  s_stall_cnt, s_flush_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ex_pipe_ctrl #(.REG_W(3), .DRAIN_CYCLES(3), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rs_vld(id_rs_vld), .id_rt(id_rt), .id_rt_vld(id_rt_vld),
      .ex_rd(ex_rd), .ex_regwrt(ex_regwrt), .ex_memread(ex_memread),
      .ex_brchcnd(ex_brchcnd), .ex_alujmp(ex_alujmp), .ex_dmp(ex_dmp), .mem_busy(mem_busy),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .exmem_stall(exmem_stall), .pc_redirect(pc_redirect),
      .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   ex_pipe_ctrl #(.REG_W(3), .DRAIN_CYCLES(3), .CNT_W(4)) u_dut_sat (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rs_vld(id_rs_vld), .id_rt(id_rt), .id_rt_vld(id_rt_vld),
      .ex_rd(ex_rd), .ex_regwrt(ex_regwrt), .ex_memread(ex_memread),
      .ex_brchcnd(ex_brchcnd), .ex_alujmp(ex_alujmp), .ex_dmp(ex_dmp), .mem_busy(mem_busy),
      .pc_stall(s_pc_stall), .ifid_stall(s_ifid_stall), .ifid_flush(s_ifid_flush),
      .idex_flush(s_idex_flush), .exmem_stall(s_exmem_stall), .pc_redirect(s_pc_redirect),
      .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs = 3'd0; id_rs_vld = 1'b0; id_rt = 3'd0; id_rt_vld = 1'b0;
      ex_rd = 3'd0; ex_regwrt = 1'b0; ex_memread = 1'b0;
      ex_brchcnd = 1'b0; ex_alujmp = 1'b0; ex_dmp = 1'b0; mem_busy = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic set_load(input logic [2:0] rs, input logic rs_v,
                           input logic [2:0] rt, input logic rt_v);
      ex_memread = 1'b1; ex_regwrt = 1'b1; ex_rd = 3'd3;
      id_rs = rs; id_rs_vld = rs_v; id_rt = rt; id_rt_vld = rt_v;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      // Outputs must stay 0 under reset even with an active branch request.
      ex_brchcnd = 1'b1;
      #1;
      chk_eq("rst_redirect", pc_redirect, 0);
      chk_eq("rst_idex_flush", idex_flush, 0);
      tick();
      tick();
      chk_eq("rst_flush_cnt", flush_cnt, 0);
      chk_eq("rst_stall_cnt", stall_cnt, 0);
      chk_eq("rst_halted", halted, 0);
      idle();
      rst = 1'b0;
      #1;

      set_load(3'd3, 1'b1, 3'd0, 1'b0);
      #1;
      chk_eq("lu_pc_stall", pc_stall, 1);
      chk_eq("lu_ifid_stall", ifid_stall, 1);
      chk_eq("lu_idex_flush", idex_flush, 1);
      chk_eq("lu_exmem_stall", exmem_stall, 0);
      tick();
      idle();
      #1;
      chk_eq("lu_release", pc_stall, 0);
      chk_eq("lu_stall_cnt", stall_cnt, 1);

      set_load(3'd0, 1'b0, 3'd3, 1'b0);
      #1;
      chk_eq("fh_pc_stall", pc_stall, 0);
      chk_eq("fh_idex_flush", idex_flush, 0);
      tick();
      chk_eq("fh_stall_cnt", stall_cnt, 1);

      set_load(3'd1, 1'b1, 3'd3, 1'b1);
      #1;
      chk_eq("lu_rt_pc_stall", pc_stall, 1);
      tick();
      idle();
      #1;
      chk_eq("lu_rt_stall_cnt", stall_cnt, 2);

      ex_brchcnd = 1'b1;
      #1;
      chk_eq("br_redirect", pc_redirect, 1);
      chk_eq("br_ifid_flush", ifid_flush, 1);
      chk_eq("br_idex_flush", idex_flush, 1);
      chk_eq("br_pc_stall", pc_stall, 0);
      tick();
      idle();
      #1;
      chk_eq("br_flush_cnt", flush_cnt, 1);

      ex_brchcnd = 1'b1;
      set_load(3'd3, 1'b1, 3'd0, 1'b0);
      #1;
      chk_eq("brlu_redirect", pc_redirect, 1);
      chk_eq("brlu_pc_stall", pc_stall, 0);
      tick();
      idle();
      #1;
      chk_eq("brlu_flush_cnt", flush_cnt, 2);
      chk_eq("brlu_stall_cnt", stall_cnt, 2);

      ex_alujmp = 1'b1;
      mem_busy  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk_eq("busy_redirect", pc_redirect, 0);
         chk_eq("busy_exmem_stall", exmem_stall, 1);
         chk_eq("busy_pc_stall", pc_stall, 1);
         tick();
      end
      mem_busy = 1'b0;
      #1;
      chk_eq("busy_end_redirect", pc_redirect, 1);
      tick();
      idle();
      #1;
      chk_eq("busy_stall_cnt", stall_cnt, 4);
      chk_eq("busy_flush_cnt", flush_cnt, 3);

      // Halt with no memory stalls: 4 edges after the dmp cycle.
      ex_dmp = 1'b1;
      #1;
      chk_eq("dmp_pc_stall", pc_stall, 1);
      chk_eq("dmp_exmem_stall", exmem_stall, 0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         ex_dmp = 1'b0;
         #1;
         chk_eq("drain_halted", halted, (k >= 4) ? 1 : 0);
      end
      chk_eq("halt_stall_cnt", stall_cnt, 8);
      ex_brchcnd = 1'b1;
      #1;
      chk_eq("halt_redirect", pc_redirect, 0);
      chk_eq("halt_exmem_stall", exmem_stall, 1);
      tick();
      idle();
      #1;
      chk_eq("halt_flush_cnt", flush_cnt, 3);
      chk_eq("halt_stall_hold", stall_cnt, 8);
      chk_eq("halt_sticky", halted, 1);

      // Halt with one busy cycle in DRAIN: 5 edges.
      do_reset();
      ex_dmp = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         ex_dmp   = 1'b0;
         mem_busy = (k == 1);
         #1;
         chk_eq("drain_busy_halted", halted, (k >= 5) ? 1 : 0);
      end
      idle();

      // Asynchronous reset in the middle of DRAIN.
      do_reset();
      ex_dmp = 1'b1;
      tick();
      idle();
      tick();
      #1;
      chk_eq("mid_drain_stall", pc_stall, 1);
      ex_brchcnd = 1'b1;
      rst = 1'b1;
      #1;
      chk_eq("arst_pc_stall", pc_stall, 0);
      chk_eq("arst_idex_flush", idex_flush, 0);
      chk_eq("arst_redirect", pc_redirect, 0);
      chk_eq("arst_stall_cnt", stall_cnt, 0);
      tick();
      idle();
      rst = 1'b0;
      #1;
      chk_eq("arst_run_stall", pc_stall, 0);
      for (int k = 0; k < 5; k++) tick();
      chk_eq("arst_no_halt", halted, 0);

      // Saturation.
      do_reset();
      mem_busy = 1'b1;
      for (int k = 0; k < 20; k++) tick();
      idle();
      #1;
      chk_eq("sat_cnt4", s_stall_cnt, 15);
      chk_eq("sat_cnt16", stall_cnt, 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ex_pipe_ctrl.md
Name: ex_pipe_ctrl

Overview:
- Pipeline sequencing controller for the execute stage of the 5-stage WISC core.
- Decides each cycle whether the front end advances, stalls or is flushed, from three sources: load-use hazards, branch/jump redirects resolved in EX, and data-memory busy.
- Sequences the halt (dmp) drain so that older instructions retire before the core freezes.
- Keeps saturating stall/flush event counters for debug.

Parameters:
- REG_W, 3, register-specifier width (8 GPRs).
- DRAIN_CYCLES, 3, cycles needed for a halt in EX to reach and pass WB.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- id_rs  in  REG_W  source A specifier of the instruction in ID
- id_rs_vld  in  1  id_rs is actually read
- id_rt  in  REG_W  source B specifier in ID
- id_rt_vld  in  1  id_rt is actually read
- ex_rd  in  REG_W  destination specifier of the instruction in EX
- ex_regwrt  in  1  EX instruction writes a register
- ex_memread  in  1  EX instruction is a load
- ex_brchcnd  in  1  conditional branch taken, resolved in EX
- ex_alujmp  in  1  register/immediate jump in EX
- ex_dmp  in  1  halt instruction is in EX
- mem_busy  in  1  data memory cannot accept or complete this cycle
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID register
- ifid_flush  out  1  clear IF/ID to NOP
- idex_flush  out  1  load a bubble into ID/EX
- exmem_stall  out  1  hold EX/MEM and MEM/WB
- pc_redirect  out  1  select jmpSource/alu target as next PC
- halted  out  1  core frozen after halt drain
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of redirects

Behaviour:
- Reset:
  - state=RUN, drain counter=0, stall_cnt=0, flush_cnt=0, halted=0.
  - All control outputs 0 while rst is high.
- States: RUN, DRAIN, HALT. The control outputs are Mealy outputs of the current state plus the inputs.
- Priority within a cycle: rst > mem_busy > ex_dmp > redirect > load-use.
- mem_busy (any state except HALT):
  - pc_stall, ifid_stall, exmem_stall = 1; idex_flush = 1.
  - No redirect and no flush this cycle; the redirect is re-evaluated next cycle from the held EX contents.
  - State and drain counter hold.
- RUN, ex_dmp=1:
  - pc_stall=ifid_stall=1, idex_flush=1.
  - Next state DRAIN; drain counter loads DRAIN_CYCLES-1.
  - Any simultaneous redirect is ignored.
- RUN, redirect (ex_brchcnd|ex_alujmp):
  - pc_redirect=1, ifid_flush=1, idex_flush=1.
  - Zero-cycle response: the correct target is fetched next cycle.
  - A simultaneous load-use condition is ignored, because the ID instruction is squashed.
- RUN, load-use: the condition is ex_memread & ex_regwrt & ((id_rs_vld & id_rs==ex_rd) | (id_rt_vld & id_rt==ex_rd)).
  - pc_stall=ifid_stall=1, idex_flush=1 for exactly one cycle.
  - There is no state change; the load leaves EX and clears the condition.
- DRAIN:
  - pc_stall=ifid_stall=1, idex_flush=1 every cycle.
  - Counter decrements when mem_busy=0.
  - At counter==0 with mem_busy=0, next state is HALT.
- HALT:
  - halted=1; pc_stall=ifid_stall=exmem_stall=1, idex_flush=1.
  - All other inputs are ignored; the only exit is rst.
- Counters:
  - stall_cnt += 1 on every cycle pc_stall=1 while state!=HALT.
  - flush_cnt += 1 on every cycle pc_redirect=1.
  - Both saturate at all-ones and never wrap.
  - Both are registered, so the value appears the cycle after the event.
- Reset mid-operation: asynchronous assertion returns the block to RUN immediately; a DRAIN in progress is abandoned.

Decomposition:
- Shared package holds the state encoding (RUN=2'd0, DRAIN=2'd1, HALT=2'd2) and the REG_W constant.
- One sub-module: sat_counter (width parameter, inc, clk, rst, count), instantiated twice.

Test Plan:
- Load-use: ex_memread=1, ex_regwrt=1, ex_rd=3, id_rs=3, id_rs_vld=1 -> pc_stall/ifid_stall/idex_flush high for 1 cycle; stall_cnt=1 next cycle.
- False hazard: same as the load-use case but id_rs_vld=0, id_rt=3, id_rt_vld=0 -> no stall; stall_cnt stays 0.
- Branch: ex_brchcnd=1 -> pc_redirect/ifid_flush/idex_flush=1 that cycle; flush_cnt=1 next cycle. Repeat with a concurrent load-use match -> still a single flush and no stall.
- mem_busy with ex_alujmp for 2 cycles, then mem_busy drops -> pc_redirect=0 for 2 cycles then 1; stall_cnt=2, flush_cnt=1.
- Halt: ex_dmp=1 in RUN with DRAIN_CYCLES=3 and mem_busy low -> halted=1 exactly 4 cycles later. With one mem_busy cycle inserted during DRAIN -> halted 5 cycles later. Afterwards ex_brchcnd is ignored.
- Reset/saturation: assert rst during DRAIN -> all outputs 0 immediately, RUN after release. With CNT_W=4, 20 stall cycles -> stall_cnt=15.
